// File: rtl/mpc_sdiv_34s_12ns_21_seq_pkg.sv
// mpc_div_pkg: shared widths, saturation bounds and FSM state type for the
// sequential signed-by-unsigned divider mpc_sdiv_34s_12ns_21_seq.
package mpc_div_pkg;

  localparam int unsigned DIN0_W = 34;  // signed dividend width
  localparam int unsigned DIN1_W = 12;  // unsigned divisor width
  localparam int unsigned DOUT_W = 21;  // signed, saturated quotient width
  localparam int unsigned CNT_W  = $clog2(DIN0_W);

  localparam logic signed [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic signed [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mpc_sdiv_34s_12ns_21_seq_if.sv
// Handshake/data bundle of mpc_sdiv_34s_12ns_21_seq.
//   master: drives ce, start, din0, din1; observes ready, done, quot, rem, ovf, dz
//   slave : the divider side
interface mpc_sdiv_34s_12ns_21_seq_if #(
  parameter int unsigned DIN0_WIDTH = mpc_div_pkg::DIN0_W,
  parameter int unsigned DIN1_WIDTH = mpc_div_pkg::DIN1_W,
  parameter int unsigned DOUT_WIDTH = mpc_div_pkg::DOUT_W
) ();

  logic                         ce;
  logic                         start;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic        [DIN1_WIDTH-1:0] din1;
  logic                         ready;
  logic                         done;
  logic signed [DOUT_WIDTH-1:0] quot;
  logic signed [DIN1_WIDTH:0]   rem;
  logic                         ovf;
  logic                         dz;

  modport master (
    output ce, start, din0, din1,
    input  ready, done, quot, rem, ovf, dz
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, done, quot, rem, ovf, dz
  );

endinterface

// File: rtl/mpc_sdiv_34s_12ns_21_seq_sat_fix.sv
// mpc_div_sat_fix: combinational result fix-up evaluated in the FIX state.
// Restores the dividend sign on quotient and remainder, optionally rounds the
// quotient magnitude half away from zero (macro MPC_DIV_ROUND_EN), saturates
// the quotient to [QMIN, QMAX] and flags divide-by-zero.
//   qmag_i : unsigned quotient magnitude     rmag_i : unsigned remainder magnitude
//   dvs_i  : divisor                         neg_i  : dividend was negative
//   quot_o : signed saturated quotient       rem_o  : signed remainder
//   ovf_o  : quotient clipped                dz_o   : divisor was zero
module mpc_div_sat_fix
  import mpc_div_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DIN0_W,
  parameter int unsigned DIN1_WIDTH = DIN1_W,
  parameter int unsigned DOUT_WIDTH = DOUT_W
) (
  input  logic [DIN0_WIDTH-1:0]        qmag_i,
  input  logic [DIN1_WIDTH-1:0]        rmag_i,
  input  logic [DIN1_WIDTH-1:0]        dvs_i,
  input  logic                         neg_i,
  output logic signed [DOUT_WIDTH-1:0] quot_o,
  output logic signed [DIN1_WIDTH:0]   rem_o,
  output logic                         ovf_o,
  output logic                         dz_o
);

  logic [DIN0_WIDTH:0]   qm;   // extra bit absorbs the rounding carry
  logic [DIN0_WIDTH:0]   lim;  // largest magnitude representable for this sign
  logic [DOUT_WIDTH-1:0] qt;
  logic [DIN1_WIDTH:0]   rx;

`ifdef MPC_DIV_ROUND_EN
  logic rnd;
  always_comb begin
    rnd = {rmag_i, 1'b0} >= {1'b0, dvs_i};
    qm  = {1'b0, qmag_i} + (DIN0_WIDTH+1)'(rnd);
  end
`else
  always_comb qm = {1'b0, qmag_i};
`endif

  always_comb begin
    lim    = (DIN0_WIDTH+1)'($unsigned(QMAX)) + (DIN0_WIDTH+1)'(neg_i);
    qt     = qm[DOUT_WIDTH-1:0];
    rx     = {1'b0, rmag_i};
    dz_o   = (dvs_i == '0);
    ovf_o  = 1'b0;
    quot_o = neg_i ? -qt : qt;
    rem_o  = neg_i ? -rx : rx;
    if (dz_o) begin
      quot_o = neg_i ? QMIN : QMAX;
      rem_o  = '0;
    end else if (qm > lim) begin
      quot_o = neg_i ? QMIN : QMAX;
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/mpc_sdiv_34s_12ns_21_seq.sv
// mpc_sdiv_34s_12ns_21_seq: radix-2 restoring divider, 34-bit signed dividend
// by 12-bit unsigned divisor, 21-bit signed saturated quotient, 13-bit signed
// remainder. One quotient bit per enabled cycle; done 36 enabled cycles after
// the start edge. Optional rounding with macro MPC_DIV_ROUND_EN.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (overrides ce)
//   bus   : slave side of mpc_sdiv_34s_12ns_21_seq_if
//           (ce, start, din0, din1 in; ready, done, quot, rem, ovf, dz out)
module mpc_sdiv_34s_12ns_21_seq
  import mpc_div_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = DIN0_W,
  parameter int unsigned DIN1_WIDTH = DIN1_W,
  parameter int unsigned DOUT_WIDTH = DOUT_W
) (
  input logic                       clk,
  input logic                       reset,
  mpc_sdiv_34s_12ns_21_seq_if.slave bus
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  // dvd_q shifts the dividend magnitude out at the MSB while quotient bits
  // shift in at the LSB; after the last CALC step it holds |quotient|.
  logic [DIN0_WIDTH-1:0]        dvd_q, dvd_d;
  logic [DIN1_WIDTH-1:0]        prem_q, prem_d;
  logic [DIN1_WIDTH-1:0]        dvs_q, dvs_d;
  logic                         neg_q, neg_d;
  logic signed [DOUT_WIDTH-1:0] quot_q, quot_d;
  logic signed [DIN1_WIDTH:0]   rem_q, rem_d;
  logic                         ovf_q, ovf_d;
  logic                         dz_q, dz_d;

  logic ready, done, load_en, calc_en, fix_en;

  logic [DIN1_WIDTH:0]          shifted;
  logic                         take;
  logic [DIN1_WIDTH-1:0]        sub;
  logic [DIN0_WIDTH-1:0]        din0_u, din0_abs;
  logic signed [DOUT_WIDTH-1:0] fix_quot;
  logic signed [DIN1_WIDTH:0]   fix_rem;
  logic                         fix_ovf, fix_dz;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset)       state_q <= IDLE;
    else if (bus.ce) state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath enables
  always_comb begin
    ready   = (state_q == IDLE);
    done    = (state_q == DONE);
    load_en = bus.ce && (state_q == IDLE) && bus.start;
    calc_en = bus.ce && (state_q == CALC);
    fix_en  = bus.ce && (state_q == FIX);
  end

  mpc_div_sat_fix #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH)
  ) u_sat_fix (
    .qmag_i (dvd_q),
    .rmag_i (prem_q),
    .dvs_i  (dvs_q),
    .neg_i  (neg_q),
    .quot_o (fix_quot),
    .rem_o  (fix_rem),
    .ovf_o  (fix_ovf),
    .dz_o   (fix_dz)
  );

  always_comb begin
    shifted  = {prem_q, dvd_q[DIN0_WIDTH-1]};
    take     = shifted >= {1'b0, dvs_q};
    // partial remainder stays below the divisor, so the difference fits
    sub      = shifted[DIN1_WIDTH-1:0] - dvs_q;
    din0_u   = bus.din0;
    din0_abs = din0_u[DIN0_WIDTH-1] ? -din0_u : din0_u;

    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    prem_d = prem_q;
    dvs_d  = dvs_q;
    neg_d  = neg_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    ovf_d  = ovf_q;
    dz_d   = dz_q;

    if (load_en) begin
      dvd_d  = din0_abs;
      neg_d  = din0_u[DIN0_WIDTH-1];
      dvs_d  = bus.din1;
      prem_d = '0;
      cnt_d  = CNT_W'(DIN0_WIDTH - 1);
    end else if (calc_en) begin
      dvd_d  = {dvd_q[DIN0_WIDTH-2:0], take};
      prem_d = take ? sub : shifted[DIN1_WIDTH-1:0];
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else if (fix_en) begin
      quot_d = fix_quot;
      rem_d  = fix_rem;
      ovf_d  = fix_ovf;
      dz_d   = fix_dz;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      prem_q <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      prem_q <= prem_d;
      dvs_q  <= dvs_d;
      neg_q  <= neg_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      ovf_q  <= ovf_d;
      dz_q   <= dz_d;
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.quot  = quot_q;
  assign bus.rem   = rem_q;
  assign bus.ovf   = ovf_q;
  assign bus.dz    = dz_q;

endmodule

// File: tb/tb_mpc_sdiv_34s_12ns_21_seq.sv
// Testbench for mpc_sdiv_34s_12ns_21_seq: directed vector table plus
// ce-freeze, start-while-busy and mid-operation reset sequences.
// Expected quotients follow the build: MPC_DIV_ROUND_EN selects the rounded column.
module tb_mpc_sdiv_34s_12ns_21_seq;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  mpc_sdiv_34s_12ns_21_seq_if bus ();

  mpc_sdiv_34s_12ns_21_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint      din0;
    int unsigned din1;
    int          q;       // truncating quotient
    int          q_rnd;   // rounded quotient
    int          r;
    bit          ovf;
    bit          ovf_rnd;
    bit          dz;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pick_q(input vec_t v);
`ifdef MPC_DIV_ROUND_EN
    return v.q_rnd;
`else
    return v.q;
`endif
  endfunction

  function automatic bit pick_ovf(input vec_t v);
`ifdef MPC_DIV_ROUND_EN
    return v.ovf_rnd;
`else
    return v.ovf;
`endif
  endfunction

  // Launches one operation and waits for done. lat is the number of edges
  // from the start-sampling edge to the edge that samples done high.
  // frz_at >= 0: drop ce for 10 cycles after that many edges, checking that
  // outputs hold prev_q. pulse_at >= 0: re-pulse start (100/1) while busy.
  task automatic run_op(input longint a, input int unsigned b, input int frz_at,
                        input int pulse_at, input logic signed [20:0] prev_q,
                        output int lat);
    @(negedge clk);
    bus.din0  = 34'(a);
    bus.din1  = 12'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 200) begin
      if (frz_at >= 0 && lat == frz_at)      bus.ce = 1'b0;
      if (frz_at >= 0 && lat == frz_at + 10) bus.ce = 1'b1;
      if (pulse_at >= 0 && lat == pulse_at) begin
        bus.start = 1'b1;
        bus.din0  = 34'sd100;
        bus.din1  = 12'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (!bus.ce) begin
        chk("frozen ready", bus.ready, 0);
        chk("frozen done",  bus.done, 0);
        chk("frozen quot",  bus.quot, prev_q);
      end
    end
    bus.start = 1'b0;
    bus.ce    = 1'b1;
    lat++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int dn;
    int eq;

    vecs[0]  = '{64'sd1000,        7,    142,      143,      6,    0, 0, 0};
    vecs[1]  = '{-64'sd1000,       7,    -142,     -143,     -6,   0, 0, 0};
    vecs[2]  = '{64'sd33554432,    1,    1048575,  1048575,  0,    1, 1, 0};
    vecs[3]  = '{-64'sd8589934592, 1,    -1048576, -1048576, 0,    1, 1, 0};
    vecs[4]  = '{-64'sd5,          0,    -1048576, -1048576, 0,    0, 0, 1};
    vecs[5]  = '{64'sd9,           3,    3,        3,        0,    0, 0, 0};
    vecs[6]  = '{64'sd5,           0,    1048575,  1048575,  0,    0, 0, 1};
    vecs[7]  = '{64'sd0,           5,    0,        0,        0,    0, 0, 0};
    vecs[8]  = '{64'sd1048575,     1,    1048575,  1048575,  0,    0, 0, 0};
    vecs[9]  = '{64'sd1048576,     1,    1048575,  1048575,  0,    1, 1, 0};
    vecs[10] = '{-64'sd1048576,    1,    -1048576, -1048576, 0,    0, 0, 0};
    vecs[11] = '{-64'sd1048577,    1,    -1048576, -1048576, 0,    1, 1, 0};
    vecs[12] = '{64'sd8589934591,  4095, 1048575,  1048575,  511,  1, 1, 0};
    vecs[13] = '{64'sd7,           2,    3,        4,        1,    0, 0, 0};
    vecs[14] = '{-64'sd7,          2,    -3,       -4,       -1,   0, 0, 0};
    vecs[15] = '{64'sd100000,      4095, 24,       24,       1720, 0, 0, 0};
    vecs[16] = '{-64'sd100000,     4095, -24,      -24,      -1720, 0, 0, 0};
    vecs[17] = '{64'sd2000,        3000, 0,        1,        2000, 0, 0, 0};
    vecs[18] = '{64'sd2097151,     2,    1048575,  1048575,  1,    0, 1, 0};

    reset     = 1'b1;
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", bus.ready, 1);
    chk("reset done",  bus.done, 0);
    chk("reset quot",  bus.quot, 0);
    chk("reset rem",   bus.rem, 0);
    chk("reset ovf",   bus.ovf, 0);
    chk("reset dz",    bus.dz, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].din0, vecs[i].din1, -1, -1, '0, lat);
      chk($sformatf("v%0d latency", i), lat, 36);
      chk($sformatf("v%0d quot", i), bus.quot, pick_q(vecs[i]));
      chk($sformatf("v%0d rem", i),  bus.rem, vecs[i].r);
      chk($sformatf("v%0d ovf", i),  bus.ovf, pick_ovf(vecs[i]));
      chk($sformatf("v%0d dz", i),   bus.dz, vecs[i].dz);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done pulse", i), bus.done, 0);
      chk($sformatf("v%0d ready back", i), bus.ready, 1);
    end

    // ce held low for 10 cycles mid-CALC: outputs hold the last table result
    eq = pick_q(vecs[0]);
    run_op(64'sd1000, 7, 10, -1, 21'(pick_q(vecs[18])), lat);
    chk("freeze latency", lat, 46);
    chk("freeze quot", bus.quot, eq);
    chk("freeze rem",  bus.rem, 6);
    @(posedge clk);
    #1;

    // start re-pulsed while busy is ignored: one done, original result
    run_op(64'sd9, 3, -1, 5, '0, lat);
    chk("busy-start latency", lat, 36);
    chk("busy-start quot", bus.quot, 3);
    chk("busy-start rem",  bus.rem, 0);
    dn = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    chk("busy-start extra done", dn, 0);

    // reset asserted 20 cycles into an operation, with ce low: reset wins
    @(negedge clk);
    bus.din0  = 34'sd1000;
    bus.din1  = 12'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre-reset busy", bus.ready, 0);
    reset  = 1'b1;
    bus.ce = 1'b0;
    @(posedge clk);
    #1;
    chk("abort ready", bus.ready, 1);
    chk("abort done",  bus.done, 0);
    chk("abort quot",  bus.quot, 0);
    chk("abort rem",   bus.rem, 0);
    chk("abort ovf",   bus.ovf, 0);
    chk("abort dz",    bus.dz, 0);
    reset  = 1'b0;
    bus.ce = 1'b1;
    dn = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    chk("abort no done", dn, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
